// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the single-port ZBT video RAM: display reads, buffered writes, frame clear.
// Optional macro VRAM_BLANK_BURST_EN turns the display slot into a write slot during blanking.
module vram_arbiter #(
  parameter logic [1:0]  DISP_SLOT   = 2'd3,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [18:0] CLEAR_WORDS = 19'd204800,
  parameter logic [35:0] CLEAR_VALUE = 36'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic        blank,
  input  logic [18:0] disp_addr,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [35:0] wr_data,
  output logic        wr_ready,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic [18:0] ram_addr,
  output logic        ram_we,
  output logic [35:0] ram_write_data
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 36;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_word_t;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  wr_word_t      fifo_mem_q [FIFO_DEPTH];

  logic          push_c, pop_c, full_c, empty_c, disp_cycle_c;
  logic [1:0]    next_slot_c;
  wr_word_t      head_c;

  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign empty_c     = (count_q == '0);
  assign wr_ready    = !full_c && !reset;
  assign push_c      = wr_req && wr_ready;
  assign head_c      = fifo_mem_q[rptr_q];
  assign next_slot_c = hcount[1:0] + 2'd1;

`ifdef VRAM_BLANK_BURST_EN
  logic unused_hcount;
  assign unused_hcount = &{1'b0, hcount[10:2]};
  assign disp_cycle_c  = (next_slot_c == DISP_SLOT) && !blank;
`else
  logic unused_hcount;
  assign unused_hcount = &{1'b0, hcount[10:2], blank};
  assign disp_cycle_c  = (next_slot_c == DISP_SLOT);
`endif

  // Slot selection for the next cycle, clear sequencer and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    pop_c       = 1'b0;

    if (disp_cycle_c) begin
      ram_addr_d = disp_addr;
    end else if (state_q == ST_CLEAR) begin
      ram_addr_d  = clr_ptr_q;
      ram_wdata_d = CLEAR_VALUE;
      ram_we_d    = 1'b1;
      clr_ptr_d   = clr_ptr_q + 19'd1;
      if (clr_ptr_q == CLEAR_WORDS - 19'd1) begin
        state_d = ST_IDLE;
      end
    end else if (!empty_c) begin
      pop_c       = 1'b1;
      ram_addr_d  = head_c.addr;
      ram_wdata_d = head_c.data;
      ram_we_d    = 1'b1;
    end

    if ((state_q == ST_IDLE) && clear_start) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
    end

    wptr_d = push_c ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop_c  ? rptr_q + PW'(1) : rptr_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clr_ptr_q   <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem_q[wptr_q] <= {wr_addr, wr_data};
    end
  end

  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_write_data = ram_wdata_q;
  assign clear_busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: slot table, FIFO fill/drain, frame clear, reset mid-clear, blank burst.
module tb_vram_arbiter;

  localparam int unsigned DEPTH   = 8;
  localparam int          NCLR    = 16;
  localparam logic [1:0]  DISP    = 2'd3;
  localparam logic [18:0] DADDR   = 19'h1A2B3;
  localparam logic [35:0] CLRVAL  = 36'h0_ABCD_1234;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic        blank;
  logic [18:0] disp_addr;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ready;
  logic        clear_start;
  logic        clear_busy;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [35:0] ram_write_data;

  vram_arbiter #(
    .DISP_SLOT  (DISP),
    .FIFO_DEPTH (DEPTH),
    .CLEAR_WORDS(19'(NCLR)),
    .CLEAR_VALUE(CLRVAL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hcount        (hcount),
    .blank         (blank),
    .disp_addr     (disp_addr),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_write_data(ram_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [18:0] a;
    logic [35:0] d;
    logic        ewe;
    logic        chka;
    logic [18:0] ea;
    logic [35:0] ed;
    logic        erdy;
  } vec_t;

  vec_t        tbl [8];
  logic [54:0] expq [$];
  int          vecs = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  bit          clr_active = 1'b0;
  int          clr_seen = 0;
  int          k = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observes the outputs valid in the current cycle against the bench's expectations
  task automatic monitor();
    logic [54:0] w;
    bit disp_chk;
`ifdef VRAM_BLANK_BURST_EN
    disp_chk = (hcount[1:0] == DISP) && !blank;
`else
    disp_chk = (hcount[1:0] == DISP);
`endif
    if (!reset && disp_chk) begin
      chk("disp_we", 64'(ram_we), 64'(0));
      chk("disp_addr", 64'(ram_addr), 64'(DADDR));
    end
    if (mon_en && ram_we) begin
      if (clr_active && clr_seen < NCLR) begin
        chk("clr_addr", 64'(ram_addr), 64'(clr_seen));
        chk("clr_data", 64'(ram_write_data), 64'(CLRVAL));
        clr_seen++;
      end else if (expq.size() == 0) begin
        chk("unexpected_write", 64'(1), 64'(0));
      end else begin
        w = expq.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(w[54:36]));
        chk("wr_data", 64'(ram_write_data), 64'(w[35:0]));
      end
    end
    if (mon_en) begin
      chk("clear_busy", 64'(clear_busy), 64'(clr_active && clr_seen < NCLR));
      chk("wr_ready", 64'(wr_ready), 64'(!reset && expq.size() < int'(DEPTH)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 hcount = hcount + 11'd1;
    @(negedge clk);
    monitor();
  endtask

  // Offers one word; records it as expected only if the FIFO takes it
  task automatic offer(output bit acc);
    wr_req  = 1'b1;
    wr_addr = 19'(256 + k);
    wr_data = 36'h3_0000_0000 + 36'(k);
    acc     = wr_ready;
    if (acc) begin
      expq.push_back({wr_addr, wr_data});
      k++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(expq.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit saw_full;
    int run, max_run, n;

    tbl[0] = '{1'b1, 19'd5, 36'h111, 1'b0, 1'b0, 19'd0,  36'h0,   1'b1};
    tbl[1] = '{1'b1, 19'd6, 36'h222, 1'b0, 1'b0, 19'd0,  36'h0,   1'b1};
    tbl[2] = '{1'b1, 19'd7, 36'h333, 1'b0, 1'b1, DADDR,  36'h0,   1'b1};
    tbl[3] = '{1'b0, 19'd0, 36'h0,   1'b1, 1'b1, 19'd5,  36'h111, 1'b1};
    tbl[4] = '{1'b0, 19'd0, 36'h0,   1'b1, 1'b1, 19'd6,  36'h222, 1'b1};
    tbl[5] = '{1'b0, 19'd0, 36'h0,   1'b1, 1'b1, 19'd7,  36'h333, 1'b1};
    tbl[6] = '{1'b0, 19'd0, 36'h0,   1'b0, 1'b1, DADDR,  36'h0,   1'b1};
    tbl[7] = '{1'b0, 19'd0, 36'h0,   1'b0, 1'b1, DADDR,  36'h0,   1'b1};

    reset = 1'b1; hcount = '0; blank = 1'b0; disp_addr = DADDR;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; clear_start = 1'b0;
    repeat (3) tick();
    chk("rst_we", 64'(ram_we), 64'(0));
    chk("rst_addr", 64'(ram_addr), 64'(0));
    chk("rst_data", 64'(ram_write_data), 64'(0));
    chk("rst_busy", 64'(clear_busy), 64'(0));
    chk("rst_ready", 64'(wr_ready), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;

    // Idle: display slot reads, no writes
    repeat (12) tick();

    // Three words land in the three write slots of one group
    mon_en = 1'b0;
    n = 0;
    while (hcount[1:0] != 2'd1 && n < 8) begin tick(); n++; end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl%0d_we", i), 64'(ram_we), 64'(tbl[i].ewe));
      if (tbl[i].chka) chk($sformatf("tbl%0d_addr", i), 64'(ram_addr), 64'(tbl[i].ea));
      if (tbl[i].ewe) chk($sformatf("tbl%0d_data", i), 64'(ram_write_data), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_ready", i), 64'(wr_ready), 64'(tbl[i].erdy));
      wr_req = tbl[i].req; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      tick();
    end
    wr_req = 1'b0;
    mon_en = 1'b1;

    // Continuous writer: FIFO fills to DEPTH, then pushes resume as slots drain
    saw_full = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!wr_ready) saw_full = 1'b1;
      offer(acc);
      tick();
    end
    wr_req = 1'b0;
    chk("fill_saw_full", 64'(saw_full), 64'(1));
    drain("fill_drain");

    // Frame clear with pushes during it and a second clear_start that must be ignored
    clear_start = 1'b1; clr_active = 1'b1; clr_seen = 0;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clr_seen < NCLR && n < 60) begin
      clear_start = (n == 5);
      if (n >= 2 && n < 14) offer(acc); else wr_req = 1'b0;
      tick();
      n++;
    end
    clear_start = 1'b0; wr_req = 1'b0;
    chk("clr_count", 64'(clr_seen), 64'(NCLR));
    chk("clr_fifo_held", 64'(expq.size()), 64'(DEPTH));
    drain("clr_drain");
    repeat (12) tick();
    clr_active = 1'b0;

    // Reset during a clear abandons it and empties the FIFO
    clear_start = 1'b1; clr_active = 1'b1; clr_seen = 0;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clr_seen < 5 && n < 30) begin
      if (n < 2) offer(acc); else wr_req = 1'b0;
      tick();
      n++;
    end
    chk("rst5_reached", 64'(clr_seen), 64'(5));
    reset = 1'b1; wr_req = 1'b0;
    expq.delete(); clr_active = 1'b0; clr_seen = 0;
    tick();
    chk("rst5_we", 64'(ram_we), 64'(0));
    chk("rst5_busy", 64'(clear_busy), 64'(0));
    chk("rst5_ready", 64'(wr_ready), 64'(0));
    reset = 1'b0;
    repeat (12) tick();

    // Blanking: burst build writes in every slot, default build keeps the read slot
    blank = 1'b1;
    run = 0; max_run = 0;
    for (int i = 0; i < 16; i++) begin
      offer(acc);
      tick();
      run = ram_we ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    wr_req = 1'b0;
    drain("blank_drain");
`ifdef VRAM_BLANK_BURST_EN
    chk("blank_run4", 64'(max_run >= 4), 64'(1));
`else
    chk("blank_run4", 64'(max_run >= 4), 64'(0));
`endif
    blank = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
